// File: rtl/of_flow_pipe_ctrl.sv
// Sequencer for the fixed-latency optical-flow velocity datapath: handshake in, tag pipeline, freeze-on-stall, flush at EOF.
// Optional stall_cycles counter is enabled by defining OF_FLOW_CTRL_STALL_CNT_EN.
module of_flow_pipe_ctrl #(
    parameter int PIPE_LATENCY = 142,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int CNT_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        pipe_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        busy,
    output logic        frame_done
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int OCC_W = $clog2(PIPE_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                         state;
    logic [PIPE_LATENCY-1:0]        tag_valid;
    logic [PIPE_LATENCY-1:0][2:0]   tag_flags;   // {sof, eol, eof}
    logic [CNT_WIDTH-1:0]           x;
    logic [CNT_WIDTH-1:0]           y;
    logic [OCC_W-1:0]               occupancy;
    logic [OCC_W-1:0]               occ_next;
    logic                           stall;
    logic                           accept;
    logic                           consume;
    logic                           at_sof;
    logic                           at_eol;
    logic                           at_eof;

    assign out_valid = tag_valid[PIPE_LATENCY-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = (state == RUN) & ~stall;
    assign accept    = in_valid & in_ready;
    assign pipe_en   = accept | ((state == FLUSH) & ~stall);
    assign consume   = out_valid & out_ready;
    assign busy      = (state != IDLE);

    assign at_sof = (x == '0) && (y == '0);
    assign at_eol = (x == CNT_WIDTH'(FRAME_WIDTH - 1));
    assign at_eof = at_eol && (y == CNT_WIDTH'(FRAME_HEIGHT - 1));

    assign out_sof = out_valid & tag_flags[PIPE_LATENCY-1][2];
    assign out_eol = out_valid & tag_flags[PIPE_LATENCY-1][1];
    assign out_eof = out_valid & tag_flags[PIPE_LATENCY-1][0];

    // NOTE: always_comb gives every output a default first so no latch is inferred.
    always_comb begin
        occ_next = occupancy;
        if (accept && !consume)
            occ_next = occupancy + OCC_W'(1);
        else if (!accept && consume)
            occ_next = occupancy - OCC_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag_valid  <= '0;
            occupancy  <= '0;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            occupancy  <= occ_next;

            // A consume without a shift must retire the last tag so it is presented once.
            if (pipe_en)
                tag_valid <= {tag_valid[PIPE_LATENCY-2:0], accept};
            else if (consume)
                tag_valid[PIPE_LATENCY-1] <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (at_eof) begin
                            x     <= '0;
                            y     <= '0;
                            state <= FLUSH;
                        end else if (at_eol) begin
                            x <= '0;
                            y <= y + CNT_WIDTH'(1);
                        end else begin
                            x <= x + CNT_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (occ_next == '0) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the flag array has no reset; flags are only observed through the reset valid bits.
    always_ff @(posedge clk) begin
        if (pipe_en)
            tag_flags <= {tag_flags[PIPE_LATENCY-2:0], {at_sof, at_eol, at_eof}};
    end

`ifdef OF_FLOW_CTRL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (state == IDLE && start)
            stall_cycles <= '0;
        else if (stall && busy && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_of_flow_pipe_ctrl.sv
// Self-checking bench for of_flow_pipe_ctrl: token-queue reference model, directed frames plus randomized traffic.
// Exercises stall_cycles as well when OF_FLOW_CTRL_STALL_CNT_EN is defined.
module tb_of_flow_pipe_ctrl;

    localparam int L    = 8;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, pipe_en, out_valid, out_sof, out_eol, out_eof, busy, frame_done;
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    of_flow_pipe_ctrl #(
        .PIPE_LATENCY(L),
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .CNT_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pipe_en   (pipe_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Reference model: each accepted pixel is a token that needs L datapath advances to reach the output.
    typedef enum {M_IDLE, M_RUN, M_FLUSH} mstate_t;
    typedef struct {
        int pix;
        int age;
    } tok_t;

    tok_t    q[$];
    mstate_t m_st = M_IDLE;
    int      m_pix = 0;
    bit      m_fd = 1'b0;
    longint  m_scnt = 0;

    int n_checks = 0;
    int n_fail = 0;
    int n_results;
    int first_ov;
    int cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic iv, input logic ordy);
        bit ov, stl, ir, acc, pe;
        int hp;
        @(negedge clk);
        start = s;
        in_valid = iv;
        out_ready = ordy;
        #1;
        ov  = (q.size() > 0) && (q[0].age == L);
        hp  = ov ? q[0].pix : -1;
        stl = ov && !ordy;
        ir  = (m_st == M_RUN) && !stl;
        acc = iv && ir;
        pe  = acc || ((m_st == M_FLUSH) && !stl);
        chk("out_valid", out_valid, ov);
        chk("in_ready", in_ready, ir);
        chk("pipe_en", pipe_en, pe);
        chk("out_sof", out_sof, ov && hp == 0);
        chk("out_eol", out_eol, ov && (hp % W) == W - 1);
        chk("out_eof", out_eof, ov && hp == NPIX - 1);
        chk("busy", busy, m_st != M_IDLE);
        chk("frame_done", frame_done, m_fd);
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, m_scnt[31:0]);
`endif
        if (out_valid && ordy) n_results++;
        if (out_valid && first_ov < 0) first_ov = cyc;
        @(posedge clk);
        if (stl && m_st != M_IDLE && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        if (ov && ordy) void'(q.pop_front());
        if (pe) foreach (q[i]) q[i].age++;
        if (acc) begin
            q.push_back('{pix: m_pix, age: 1});
            if (m_pix == NPIX - 1) begin
                m_pix = 0;
                m_st  = M_FLUSH;
            end else begin
                m_pix++;
            end
        end
        m_fd = 1'b0;
        if (m_st == M_IDLE && s) begin
            m_st   = M_RUN;
            m_pix  = 0;
            m_scnt = 0;
        end else if (m_st == M_FLUSH && q.size() == 0) begin
            m_st = M_IDLE;
            m_fd = 1'b1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_st = M_IDLE;
        m_pix = 0;
        m_fd = 1'b0;
        m_scnt = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_pipe_en", pipe_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_flags", {out_sof, out_eol, out_eof}, 3'b000);
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    endtask

    // mode 0 stream, 1 bubbles, 2 random, 3 start mid-run, 4 input pause, 5 backpressure
    task automatic run_frame(input int mode);
        bit done;
        logic s, iv, ordy;
        n_results = 0;
        first_ov = -1;
        step(1'b1, 1'b0, 1'b1);
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
        chk("stall_cycles_cleared", stall_cycles, 32'd0);
`endif
        cyc = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            s = 1'b0;
            iv = 1'b1;
            ordy = 1'b1;
            case (mode)
                1: iv = (c % 3 == 0);
                2: begin
                    iv = 1'($urandom_range(1, 0));
                    ordy = ($urandom_range(3, 0) != 0);
                end
                3: s = (c == 3);
                4: iv = (c < 3 || c >= 20);
                5: ordy = !(c >= 10 && c < 15);
                default: ;
            endcase
            step(s, iv, ordy);
            if (m_st == M_IDLE) done = 1'b1;
        end
        if (!done) chk("frame_timeout", 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("result_count", n_results, NPIX);
        if (mode == 0 || mode == 5) chk("first_latency", first_ov, L);
    endtask

    initial begin
        do_reset();

        // in_valid while idle must not be accepted
        repeat (3) step(1'b0, 1'b1, 1'b1);

        run_frame(0);
        run_frame(5);
`ifdef OF_FLOW_CTRL_STALL_CNT_EN
        chk("stall_cycles_bp", stall_cycles, 32'd5);
`endif
        run_frame(1);
        run_frame(4);
        run_frame(3);
        repeat (3) run_frame(2);

        // reset after five accepts, then a clean frame
        step(1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        run_frame(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
